sys_cmd_tx: RTL and testbench

Serial command transmitter that drives the SoC test-command line (SYS_CMD) toward the timing master and WIBs. It is the transmit-side counterpart of the timing endpoint receive path. Register-programmed command bytes are queued in a small FIFO and serialised as framed, parity-protected words at a fixed bit period derived from clk_axi. It sits in top_RTL between the R/W register block and the SYS_CMD output pin.

---
 rtl/sys_cmd_pkg.sv | 16 +
 rtl/sys_cmd_fifo.sv | 62 ++++++
 rtl/sys_cmd_tx.sv | 151 +++++++++++++++
 tb/tb_sys_cmd_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared types and framing constants for the SYS_CMD serial transmitter.
package sys_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned FrameBits = 11;
    localparam logic        StartBit  = 1'b0;
    localparam logic        StopBit   = 1'b1;

endpackage

// File: rtl/sys_cmd_fifo.sv
// Small synchronous FIFO holding command bytes awaiting transmission.
module sys_cmd_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_axi,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wdata,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [LvlW-1:0]   level_q, level_d;
    logic              full_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            level_q <= level_d;
            // Full flag is registered from the next level so it tracks occupancy exactly.
            full_q  <= (level_d == LvlW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_axi) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign full  = full_q;
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/sys_cmd_tx.sv
// SYS_CMD transmitter: queues command bytes and sends them as start/data/even-parity/stop frames.
module sys_cmd_tx
    import sys_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                        clk_axi,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic                        sys_cmd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 tx_count
);

    localparam int unsigned       BitW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [15:0]       BaudLoad = 16'(CLK_DIV - 1);
    localparam logic [BitW-1:0]   LastBit  = BitW'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [15:0]       tx_count_q, tx_count_d;
    logic              sys_cmd_q, sys_cmd_d;
    logic              push, pop, full, empty, baud_done;
    logic [DATA_W-1:0] head;

    assign push      = cmd_valid && !full;
    assign baud_done = (baud_q == '0);

    sys_cmd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_axi (clk_axi),
        .rst     (rst),
        .push    (push),
        .wdata   (cmd_data),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = (state_q == StIdle) ? baud_q : baud_q - 16'd1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_count_d = tx_count_q;
        pop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && !empty) begin
                    state_d  = StStart;
                    pop      = 1'b1;
                    shift_d  = head;
                    parity_d = ^head;
                    baud_d   = BaudLoad;
                end
            end
            StStart: begin
                if (baud_done) begin
                    state_d = StData;
                    bit_d   = '0;
                    baud_d  = BaudLoad;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = BaudLoad;
                    if (bit_q == LastBit) begin
                        state_d = StParity;
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (baud_done) begin
                    state_d = StStop;
                    baud_d  = BaudLoad;
                end
            end
            StStop: begin
                if (baud_done) begin
                    tx_count_d = tx_count_q + 16'd1;
                    // Chain straight into the next start bit so frames are gapless.
                    if (enable && !empty) begin
                        state_d  = StStart;
                        pop      = 1'b1;
                        shift_d  = head;
                        parity_d = ^head;
                        baud_d   = BaudLoad;
                    end else begin
                        state_d = StIdle;
                        baud_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sys_cmd_d = StopBit;
        unique case (state_q)
            StStart:  sys_cmd_d = StartBit;
            StData:   sys_cmd_d = shift_q[0];
            StParity: sys_cmd_d = parity_q;
            default:  sys_cmd_d = StopBit;
        endcase
    end

    always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_count_q <= '0;
            sys_cmd_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_count_q <= tx_count_d;
            sys_cmd_q  <= sys_cmd_d;
        end
    end

    assign cmd_ready = !full;
    assign sys_cmd   = sys_cmd_q;
    assign tx_busy   = (state_q != StIdle);
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_sys_cmd_tx.sv
// Self-checking bench for sys_cmd_tx against a frame-timeline reference model.
module tb_sys_cmd_tx;
    import sys_cmd_pkg::*;

    localparam int unsigned Div         = 8;
    localparam int unsigned Depth       = 4;
    localparam int unsigned FrameCycles = FrameBits * Div;
    localparam int unsigned Budget      = 2000;

    logic        clk_axi = 1'b0;
    logic        rst, enable, cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready, sys_cmd, tx_busy;
    logic [2:0]  fifo_level;
    logic [15:0] tx_count;

    logic        enable2, cmd_valid2;
    logic [7:0]  cmd_data2;
    logic        cmd_ready2, sys_cmd2, tx_busy2;
    logic [2:0]  fifo_level2;
    logic [15:0] tx_count2;

    always #5 clk_axi = ~clk_axi;

    sys_cmd_tx #(.CLK_DIV(Div), .FIFO_DEPTH(Depth), .DATA_W(8)) dut (
        .clk_axi (clk_axi), .rst (rst), .enable (enable), .cmd_data (cmd_data),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .sys_cmd (sys_cmd),
        .tx_busy (tx_busy), .fifo_level (fifo_level), .tx_count (tx_count)
    );

    sys_cmd_tx #(.CLK_DIV(2), .FIFO_DEPTH(Depth), .DATA_W(8)) dut_div2 (
        .clk_axi (clk_axi), .rst (rst), .enable (enable2), .cmd_data (cmd_data2),
        .cmd_valid (cmd_valid2), .cmd_ready (cmd_ready2), .sys_cmd (sys_cmd2),
        .tx_busy (tx_busy2), .fifo_level (fifo_level2), .tx_count (tx_count2)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: queued bytes plus position within the current 11-bit frame.
    logic [7:0]  m_q[$];
    bit          m_active;
    int          m_elapsed;
    logic [10:0] m_frame;
    logic [15:0] m_count;
    logic        exp_line;
    bit          m_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active  = 1'b0;
        m_elapsed = 0;
        m_count   = '0;
        exp_line  = 1'b1;
    endtask

    task automatic model_step();
        logic do_push;
        do_push  = cmd_valid && (m_q.size() < Depth);
        // Line shows the frame bit one cycle after the frame position it encodes.
        exp_line = m_active ? m_frame[m_elapsed / Div] : 1'b1;
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FrameCycles) begin
                m_active = 1'b0;
                m_count++;
            end
        end
        if (!m_active && enable && m_q.size() > 0) begin
            m_frame   = make_frame(m_q.pop_front());
            m_active  = 1'b1;
            m_elapsed = 0;
        end
        if (do_push) m_q.push_back(cmd_data);
    endtask

    always begin
        @(posedge clk_axi);
        if (rst) model_reset();
        else     model_step();
        #1;
        if (m_on) begin
            check_eq("sys_cmd", 32'(sys_cmd), 32'(exp_line));
            check_eq("tx_busy", 32'(tx_busy), 32'(m_active));
            check_eq("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < Depth));
            check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            check_eq("tx_count", 32'(tx_count), 32'(m_count));
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [7:0] b);
        int n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < Budget) begin
            @(negedge clk_axi);
            n++;
        end
        check_eq("send_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk_axi);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_axi);
    endtask

    initial begin
        logic [10:0] f2;
        int          n;
        rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
        enable2 = 1'b1; cmd_valid2 = 1'b0; cmd_data2 = '0;
        wait_cycles(3);
        #2 rst = 1'b0;
        m_on = 1'b1;
        @(negedge clk_axi);
        check_eq("reset_count", 32'(tx_count), 32'd0);

        // Single frame of 0xA5.
        send(8'hA5);
        wait_cycles(FrameCycles + 10);
        check_eq("t1_count", 32'(tx_count), 32'd1);

        // Three back-to-back frames.
        send(8'h01); send(8'h02); send(8'h03);
        wait_cycles(3 * FrameCycles + 10);
        check_eq("t2_count", 32'(tx_count), 32'd4);

        // Fill while disabled, then overflow attempt.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        cmd_data = 8'h55; cmd_valid = 1'b1;
        wait_cycles(4);
        check_eq("t3_ready_low", 32'(cmd_ready), 32'd0);
        check_eq("t3_level", 32'(fifo_level), 32'd4);
        check_eq("t3_line_idle", 32'(sys_cmd), 32'd1);
        enable = 1'b1;
        n = 0;
        while (!cmd_ready && n < Budget) begin
            @(negedge clk_axi);
            n++;
        end
        check_eq("t3_fifth_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk_axi);
        cmd_valid = 1'b0;
        wait_cycles(5 * FrameCycles + 10);
        check_eq("t3_count", 32'(tx_count), 32'd9);

        // Disable mid-frame: frame completes, second byte stays queued.
        send(8'hC3); send(8'h3C);
        wait_cycles(40);
        enable = 1'b0;
        n = 0;
        while (tx_busy && n < Budget) begin
            @(negedge clk_axi);
            n++;
        end
        check_eq("t4_idle", 32'(tx_busy), 32'd0);
        check_eq("t4_level", 32'(fifo_level), 32'd1);
        wait_cycles(10);
        check_eq("t4_line_idle", 32'(sys_cmd), 32'd1);
        enable = 1'b1;
        @(posedge clk_axi); #1;
        check_eq("t4_restart", 32'(tx_busy), 32'd1);
        wait_cycles(FrameCycles + 10);
        check_eq("t4_count", 32'(tx_count), 32'd11);

        // Reset in the middle of data bit 3.
        send(8'h96);
        wait_cycles(37);
        check_eq("t5_busy_before", 32'(tx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_line", 32'(sys_cmd), 32'd1);
        check_eq("t5_level", 32'(fifo_level), 32'd0);
        check_eq("t5_count", 32'(tx_count), 32'd0);
        check_eq("t5_ready", 32'(cmd_ready), 32'd1);
        check_eq("t5_busy", 32'(tx_busy), 32'd0);
        @(negedge clk_axi);
        rst = 1'b0;

        // Randomized traffic with occasional enable toggles.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_axi);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_data  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
        end
        @(negedge clk_axi);
        cmd_valid = 1'b0;
        enable    = 1'b1;
        wait_cycles(6 * FrameCycles);
        check_eq("rand_drained", 32'(fifo_level), 32'd0);

        // CLK_DIV=2 instance: tx_count wrap and two-cycle bits.
        force dut_div2.tx_count_q = 16'hFFFF;
        @(negedge clk_axi);
        release dut_div2.tx_count_q;
        @(negedge clk_axi);
        check_eq("t6_preload", 32'(tx_count2), 32'hFFFF);
        cmd_data2 = 8'h3C; cmd_valid2 = 1'b1;
        @(negedge clk_axi);
        cmd_valid2 = 1'b0;
        f2 = make_frame(8'h3C);
        @(posedge clk_axi);
        for (int k = 0; k < 22; k++) begin
            @(posedge clk_axi); #1;
            check_eq($sformatf("t6_bit%0d", k), 32'(sys_cmd2), 32'(f2[k / 2]));
        end
        check_eq("t6_wrap", 32'(tx_count2), 32'd0);
        check_eq("t6_busy", 32'(tx_busy2), 32'd0);
        @(posedge clk_axi); #1;
        check_eq("t6_line_idle", 32'(sys_cmd2), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
